// File: rtl/esp_srst_sequencer_if.sv
// Soft-reset sequencer bundle: ESP link request and drain acks in,
// per-domain resets and status out.
interface esp_srst_sequencer_if #(
   parameter int NDOM = 4
);
   logic            srst_in;
   logic [NDOM-1:0] drain_ack;
   logic            drain_req;
   logic [NDOM-1:0] domain_rstn;
   logic            busy;
   logic            seq_done;
   logic            drain_timeout;

   modport master (
      output srst_in, drain_ack,
      input  drain_req, domain_rstn, busy, seq_done, drain_timeout
   );

   modport slave (
      input  srst_in, drain_ack,
      output drain_req, domain_rstn, busy, seq_done, drain_timeout
   );
endinterface

// File: rtl/esp_srst_sequencer.sv
// Turns the ESP soft-reset level into drain, assert-all, then
// index-ordered per-domain reset release.
module esp_srst_sequencer #(
   parameter int NDOM          = 4,
   parameter int GAP_CYCLES    = 16,
   parameter int DRAIN_TIMEOUT = 1024
) (
   input logic                 clk,
   input logic                 rstn,
   esp_srst_sequencer_if.slave bus
);
   localparam int MAXC  = (GAP_CYCLES > DRAIN_TIMEOUT) ?
                          GAP_CYCLES : DRAIN_TIMEOUT;
   localparam int CNT_W = $clog2(MAXC) + 1;
   localparam int IDX_W = (NDOM > 1) ? $clog2(NDOM) : 1;

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDOM - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      HOLD,
      RELEASE
   } state_e;

   state_e           state_q, state_d;
   logic             srst_q, srst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [NDOM-1:0]  dom_q, dom_d;
   logic             dreq_q, dreq_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dto_q, dto_d;
   logic             rise;
   logic             all_ack;

   assign rise    = bus.srst_in & ~srst_q;
   assign all_ack = &bus.drain_ack;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         srst_q  <= 1'b0;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '1;
         dreq_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dto_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         srst_q  <= srst_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         dreq_q  <= dreq_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dto_q   <= dto_d;
      end
   end

   always_comb begin
      state_d = state_q;
      srst_d  = bus.srst_in;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      dreq_d  = dreq_q;
      done_d  = 1'b0;
      dto_d   = dto_q;
      unique case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = DRAIN;
               dreq_d  = 1'b1;
               cnt_d   = '0;
               dto_d   = 1'b0;
            end
         end
         DRAIN: begin
            if (all_ack || cnt_q == DT_LAST) begin
               state_d = HOLD;
               dreq_d  = 1'b0;
               dom_d   = '0;
               cnt_d   = '0;
               if (!all_ack) dto_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!bus.srst_in && cnt_q == GAP_LAST) begin
               dom_d[0] = 1'b1;
               cnt_d    = '0;
               if (NDOM == 1) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RELEASE;
                  idx_d   = IDX_W'(1);
               end
            end else if (cnt_q != GAP_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RELEASE: begin
            // Restart skips DRAIN: traffic is already stopped
            if (rise) begin
               state_d = HOLD;
               dom_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
               dom_d[idx_q] = 1'b1;
               cnt_d        = '0;
               idx_d        = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign bus.drain_req     = dreq_q;
   assign bus.domain_rstn   = dom_q;
   assign bus.busy          = busy_q;
   assign bus.seq_done      = done_q;
   assign bus.drain_timeout = dto_q;
endmodule

// File: tb/tb_esp_srst_sequencer.sv
// Randomized bench for esp_srst_sequencer against a timestamp-based
// model of the drain / hold / ordered-release sequence.
module tb_esp_srst_sequencer;
   localparam int NDOM = 4;
   localparam int GAP  = 16;
   localparam int DT   = 1024;

   localparam int M_IDLE = 0;
   localparam int M_DRN  = 1;
   localparam int M_HOLD = 2;
   localparam int M_REL  = 3;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   esp_srst_sequencer_if #(.NDOM(NDOM)) bus ();

   esp_srst_sequencer #(
      .NDOM         (NDOM),
      .GAP_CYCLES   (GAP),
      .DRAIN_TIMEOUT(DT)
   ) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   int              m_mode = M_IDLE;
   int              m_ent  = 0;
   int              m_rel0 = 0;
   bit              m_prev = 1'b0;
   logic [NDOM-1:0] m_dom  = '1;
   bit              m_dreq = 1'b0;
   bit              m_busy = 1'b0;
   bit              m_done = 1'b0;
   bit              m_dto  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  tag, cyc_n, got, exp);
      end
   endtask

   // One clock edge of the reference: phases tracked by entry times
   task automatic model_step();
      bit rise;
      bit ack;
      int k;
      int i;
      m_done = 1'b0;
      if (!rstn) begin
         m_mode = M_IDLE;
         m_prev = 1'b0;
         m_dom  = '1;
         m_dreq = 1'b0;
         m_dto  = 1'b0;
         m_busy = 1'b0;
         return;
      end
      rise   = bus.srst_in && !m_prev;
      m_prev = bus.srst_in;
      ack    = (bus.drain_ack == {NDOM{1'b1}});
      case (m_mode)
         M_IDLE: if (rise) begin
            m_mode = M_DRN;
            m_ent  = cyc_n;
            m_dreq = 1'b1;
            m_dto  = 1'b0;
         end
         M_DRN: if (ack || cyc_n - m_ent == DT) begin
            m_mode = M_HOLD;
            m_ent  = cyc_n;
            m_dreq = 1'b0;
            m_dom  = '0;
            if (!ack) m_dto = 1'b1;
         end
         M_HOLD: if (!bus.srst_in && cyc_n - m_ent >= GAP) begin
            m_rel0   = cyc_n;
            m_dom[0] = 1'b1;
            if (NDOM == 1) begin
               m_mode = M_IDLE;
               m_done = 1'b1;
            end else begin
               m_mode = M_REL;
            end
         end
         default: begin
            k = cyc_n - m_rel0;
            if (rise) begin
               m_mode = M_HOLD;
               m_ent  = cyc_n;
               m_dom  = '0;
            end else if (k % GAP == 0) begin
               i        = k / GAP;
               m_dom[i] = 1'b1;
               if (i == NDOM - 1) begin
                  m_mode = M_IDLE;
                  m_done = 1'b1;
               end
            end
         end
      endcase
      m_busy = (m_mode != M_IDLE);
   endtask

   task automatic step();
      @(posedge clk);
      cyc_n++;
      model_step();
      #1;
      chk("domain_rstn", 32'(bus.domain_rstn), 32'(m_dom));
      chk("drain_req", 32'(bus.drain_req), 32'(m_dreq));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("seq_done", 32'(bus.seq_done), 32'(m_done));
      chk("drain_timeout", 32'(bus.drain_timeout), 32'(m_dto));
   endtask

   task automatic scen(input int len, input int ackp,
                       input bit rerise, input bit rstp);
      int rr_at;
      int rr_left;
      int rp_at;
      rr_at   = $urandom_range(2, 40);
      rp_at   = $urandom_range(2, 60);
      rr_left = 0;
      bus.srst_in = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == len) bus.srst_in = 1'b0;
         case (ackp)
            0:       bus.drain_ack = '1;
            1:       bus.drain_ack = ($urandom_range(0, 7) == 0) ?
                                     {NDOM{1'b1}} : NDOM'($urandom());
            default: bus.drain_ack = '0;
         endcase
         if (rr_left > 0) begin
            rr_left--;
            if (rr_left == 0) bus.srst_in = 1'b0;
         end else if (rerise && m_mode == M_REL && i > len) begin
            if (rr_at == 0) begin
               bus.srst_in = 1'b1;
               rr_left     = 2;
               rerise      = 1'b0;
            end else begin
               rr_at--;
            end
         end
         rstn = !(rstp && i == rp_at);
         step();
         if (i > len + 2 && m_mode == M_IDLE && rr_left == 0) break;
      end
      bus.srst_in = 1'b0;
      rstn        = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      bus.srst_in   = 1'b1;
      bus.drain_ack = '1;
      rstn          = 1'b0;
      repeat (2) step();
      scen(100, 0, 1'b0, 1'b0);
      scen(1, 2, 1'b0, 1'b0);
      scen(3, 0, 1'b1, 1'b0);
      scen(20, 0, 1'b0, 1'b1);
      for (int s = 0; s < 30; s++) begin
         scen($urandom_range(1, 40),
              (s % 10 == 9) ? 2 : $urandom_range(0, 1),
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
